// File: rtl/parity_stream_arbiter_if.sv
// Stream bundle between N_PORTS requesters, the shared parity checker and its response sink.
// The slave modport is the arbiter's view; master is the view of the surrounding environment.
interface parity_stream_arbiter_if #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned ID_W    = 2
);
    logic [N_PORTS-1:0]   axis_s_tvalid;
    logic [8*N_PORTS-1:0] axis_s_tdata;
    logic [N_PORTS-1:0]   axis_s_tlast;
    logic [N_PORTS-1:0]   axis_s_tready;
    logic                 axis_m_tvalid;
    logic [7:0]           axis_m_tdata;
    logic                 axis_m_tlast;
    logic [ID_W-1:0]      axis_m_tid;
    logic                 axis_m_tready;

    modport slave (
        input  axis_s_tvalid,
        input  axis_s_tdata,
        input  axis_s_tlast,
        output axis_s_tready,
        output axis_m_tvalid,
        output axis_m_tdata,
        output axis_m_tlast,
        output axis_m_tid,
        input  axis_m_tready
    );

    modport master (
        output axis_s_tvalid,
        output axis_s_tdata,
        output axis_s_tlast,
        input  axis_s_tready,
        input  axis_m_tvalid,
        input  axis_m_tdata,
        input  axis_m_tlast,
        input  axis_m_tid,
        output axis_m_tready
    );
endinterface

// File: rtl/parity_stream_arbiter.sv
// Round-robin, packet-granular arbiter feeding one XOR parity accumulator; each completed
// packet yields a tagged response burst (FF for odd parity, AB/12/DE for even).
module parity_stream_arbiter #(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  a_clk,
    input  logic                  axis_aresetn,
    parity_stream_arbiter_if.slave bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      last_len
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        RESP0  = 3'd2,
        RESP1  = 3'd3,
        RESP2  = 3'd4
    } state_e;

    localparam logic [7:0]       ODD_BEAT  = 8'hFF;
    localparam logic [7:0]       EVEN_B0   = 8'hAB;
    localparam logic [7:0]       EVEN_B1   = 8'h12;
    localparam logic [7:0]       EVEN_B2   = 8'hDE;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [ID_W-1:0]  LAST_PORT = ID_W'(N_PORTS - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              parity_q, parity_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  last_len_q, last_len_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic [7:0]        m_tdata_q, m_tdata_d;
    logic              m_tlast_q, m_tlast_d;
    logic [ID_W-1:0]   m_tid_q, m_tid_d;
    logic              busy_q, busy_d;

    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic              req_any;
    logic [ID_W-1:0]   rr_pick;
    int unsigned       rr_idx;
    logic [N_PORTS-1:0] s_tready;
    logic [CNT_W-1:0]  cnt_inc;
    logic              parity_acc;

    // Mux the granted requester's beat onto a single lane.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_valid = bus.axis_s_tvalid[i];
                sel_last  = bus.axis_s_tlast[i];
                sel_data  = bus.axis_s_tdata[8*i +: 8];
            end
        end
    end

    // First requester at or after rr_ptr, wrapping modulo N_PORTS.
    always_comb begin
        req_any = 1'b0;
        rr_pick = rr_ptr_q;
        rr_idx  = 0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            rr_idx = 32'(rr_ptr_q) + k;
            if (rr_idx >= N_PORTS) begin
                rr_idx = rr_idx - N_PORTS;
            end
            for (int unsigned j = 0; j < N_PORTS; j++) begin
                if (!req_any && (rr_idx == j) && bus.axis_s_tvalid[j]) begin
                    req_any = 1'b1;
                    rr_pick = ID_W'(j);
                end
            end
        end
    end

    // Ready is decoded from registered state and grant only, so at most one bit is ever high.
    always_comb begin
        s_tready = '0;
        for (int unsigned j = 0; j < N_PORTS; j++) begin
            s_tready[j] = (state_q == STREAM) && (grant_q == ID_W'(j));
        end
    end

    assign cnt_inc    = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
    assign parity_acc = parity_q ^ (^sel_data);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        parity_d   = parity_q;
        beat_cnt_d = beat_cnt_q;
        last_len_d = last_len_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d    = rr_pick;
                    parity_d   = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (sel_valid) begin
                    parity_d   = parity_acc;
                    beat_cnt_d = cnt_inc;
                    // Response beat 0 is loaded here so tvalid rises right after tlast.
                    if (sel_last) begin
                        last_len_d = cnt_inc;
                        rr_ptr_d   = (grant_q == LAST_PORT) ? '0 : grant_q + ID_W'(1);
                        m_tvalid_d = 1'b1;
                        m_tid_d    = grant_q;
                        m_tdata_d  = parity_acc ? ODD_BEAT : EVEN_B0;
                        m_tlast_d  = parity_acc;
                        state_d    = RESP0;
                    end
                end
            end
            RESP0: begin
                if (bus.axis_m_tready) begin
                    if (parity_q) begin
                        m_tvalid_d = 1'b0;
                        m_tdata_d  = 8'h00;
                        m_tlast_d  = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        m_tdata_d  = EVEN_B1;
                        state_d    = RESP1;
                    end
                end
            end
            RESP1: begin
                if (bus.axis_m_tready) begin
                    m_tdata_d = EVEN_B2;
                    m_tlast_d = 1'b1;
                    state_d   = RESP2;
                end
            end
            RESP2: begin
                if (bus.axis_m_tready) begin
                    m_tvalid_d = 1'b0;
                    m_tdata_d  = 8'h00;
                    m_tlast_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge a_clk) begin
        if (axis_aresetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            parity_q   <= 1'b0;
            beat_cnt_q <= '0;
            last_len_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 8'h00;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            parity_q   <= parity_d;
            beat_cnt_q <= beat_cnt_d;
            last_len_q <= last_len_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.axis_s_tready = s_tready;
    assign bus.axis_m_tvalid = m_tvalid_q;
    assign bus.axis_m_tdata  = m_tdata_q;
    assign bus.axis_m_tlast  = m_tlast_q;
    assign bus.axis_m_tid    = m_tid_q;
    assign busy              = busy_q;
    assign last_len          = last_len_q;

endmodule

// File: tb/tb_parity_stream_arbiter.sv
// Directed bench for parity_stream_arbiter: hand-computed responses, grant order,
// stall behaviour, mid-packet reset and mid-packet valid drops.
module tb_parity_stream_arbiter;

    localparam int unsigned N_PORTS = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 16;

    logic             a_clk;
    logic             axis_aresetn;
    logic             busy;
    logic [CNT_W-1:0] last_len;
    int               checks;
    int               errors;

    parity_stream_arbiter_if #(.N_PORTS(N_PORTS), .ID_W(ID_W)) bus ();

    parity_stream_arbiter #(
        .N_PORTS(N_PORTS),
        .ID_W   (ID_W),
        .CNT_W  (CNT_W)
    ) dut (
        .a_clk       (a_clk),
        .axis_aresetn(axis_aresetn),
        .bus         (bus),
        .busy        (busy),
        .last_len    (last_len)
    );

    initial begin
        a_clk = 1'b0;
        forever #5 a_clk = ~a_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
        bus.axis_s_tvalid[p]      = v;
        bus.axis_s_tdata[8*p +: 8] = d;
        bus.axis_s_tlast[p]       = l;
    endtask

    // Present one beat on port p and wait (bounded) until it is accepted.
    task automatic send_beat(input int p, input logic [7:0] d, input logic l);
        logic rdy;
        int   n;
        drive(p, 1'b1, d, l);
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 40) begin
            rdy = bus.axis_s_tready[p];
            tick();
            n++;
        end
        if (!rdy) check($sformatf("beat_p%0d_timeout", p), 32'(rdy), 1);
        if (l) drive(p, 1'b0, 8'h00, 1'b0);
    endtask

    // Called one cycle after the tlast transfer with m_tready high.
    task automatic expect_resp(input string tag, input logic [ID_W-1:0] tid, input bit odd);
        logic [7:0] exp_d [3];
        int         nb;
        if (odd) begin
            nb       = 1;
            exp_d[0] = 8'hFF;
            exp_d[1] = 8'h00;
            exp_d[2] = 8'h00;
        end else begin
            nb    = 3;
            exp_d = '{8'hAB, 8'h12, 8'hDE};
        end
        for (int i = 0; i < nb; i++) begin
            check($sformatf("%s_b%0d_valid", tag, i), 32'(bus.axis_m_tvalid), 1);
            check($sformatf("%s_b%0d_data", tag, i), 32'(bus.axis_m_tdata), 32'(exp_d[i]));
            check($sformatf("%s_b%0d_last", tag, i), 32'(bus.axis_m_tlast), 32'(i == nb - 1));
            check($sformatf("%s_b%0d_tid", tag, i), 32'(bus.axis_m_tid), 32'(tid));
            tick();
        end
        check({tag, "_end_valid"}, 32'(bus.axis_m_tvalid), 0);
        check({tag, "_end_data"}, 32'(bus.axis_m_tdata), 0);
        check({tag, "_end_last"}, 32'(bus.axis_m_tlast), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(bus.axis_s_tready), 0);
        check({tag, "_mvalid"}, 32'(bus.axis_m_tvalid), 0);
        check({tag, "_mdata"}, 32'(bus.axis_m_tdata), 0);
        check({tag, "_mlast"}, 32'(bus.axis_m_tlast), 0);
        check({tag, "_mtid"}, 32'(bus.axis_m_tid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_len"}, 32'(last_len), 0);
    endtask

    task automatic do_reset();
        axis_aresetn = 1'b1;
        tick();
        tick();
        axis_aresetn = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        axis_aresetn        = 1'b1;
        bus.axis_s_tvalid   = '0;
        bus.axis_s_tdata    = '0;
        bus.axis_s_tlast    = '0;
        bus.axis_m_tready   = 1'b1;
        tick();
        tick();
        check_reset("rst");
        axis_aresetn = 1'b0;

        // T1: port 0, 01 02 03 -> even parity
        send_beat(0, 8'h01, 1'b0);
        send_beat(0, 8'h02, 1'b0);
        check("t1_pre_mvalid", 32'(bus.axis_m_tvalid), 0);
        send_beat(0, 8'h03, 1'b1);
        check("t1_ready_drop", 32'(bus.axis_s_tready), 0);
        expect_resp("t1", 2'd0, 1'b0);
        check("t1_len", 32'(last_len), 3);

        // T2: port 2 single beat 07 -> odd parity
        send_beat(2, 8'h07, 1'b1);
        expect_resp("t2", 2'd2, 1'b1);
        check("t2_len", 32'(last_len), 1);

        // T3: all ports requesting from a fresh pointer
        do_reset();
        begin : t3
            int           left [4];
            int           bi   [4];
            int           nbeat[4];
            int           order[$];
            int           tids [$];
            int           exp_order[5];
            logic [3:0]   rdy;
            logic [3:0]   vld;
            left      = '{2, 1, 1, 1};
            bi        = '{0, 0, 0, 0};
            nbeat     = '{0, 0, 0, 0};
            exp_order = '{0, 1, 2, 3, 0};
            for (int cyc = 0; cyc < 200 && (order.size() < 5 || busy); cyc++) begin
                for (int p = 0; p < 4; p++) begin
                    drive(p, left[p] > 0, 8'(16 * p + bi[p] + 1), bi[p] == 1);
                end
                rdy = bus.axis_s_tready;
                vld = bus.axis_s_tvalid;
                check("t3_ready_onehot", 32'($countones(rdy) <= 1), 1);
                if (bus.axis_m_tvalid && bus.axis_m_tlast) tids.push_back(int'(bus.axis_m_tid));
                tick();
                for (int p = 0; p < 4; p++) begin
                    if (rdy[p] && vld[p]) begin
                        nbeat[p]++;
                        if (bi[p] == 1) begin
                            order.push_back(p);
                            left[p]--;
                            bi[p] = 0;
                        end else begin
                            bi[p] = 1;
                        end
                    end
                end
            end
            check("t3_npkts", 32'(order.size()), 5);
            check("t3_nresp", 32'(tids.size()), 5);
            for (int i = 0; i < 5; i++) begin
                if (i < order.size()) check($sformatf("t3_grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
                if (i < tids.size()) check($sformatf("t3_tid%0d", i), 32'(tids[i]), 32'(exp_order[i]));
            end
            check("t3_beats_p0", 32'(nbeat[0]), 4);
            check("t3_beats_p1", 32'(nbeat[1]), 2);
            check("t3_beats_p2", 32'(nbeat[2]), 2);
            check("t3_beats_p3", 32'(nbeat[3]), 2);
            check("t3_len", 32'(last_len), 2);
        end

        // T4: port 1 even packet, stall on beat 12 while port 2 waits
        send_beat(1, 8'h03, 1'b1);
        check("t4_b0_data", 32'(bus.axis_m_tdata), 32'h00AB);
        check("t4_b0_tid", 32'(bus.axis_m_tid), 1);
        tick();
        check("t4_b1_data", 32'(bus.axis_m_tdata), 32'h0012);
        bus.axis_m_tready = 1'b0;
        drive(2, 1'b1, 8'h80, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_stall%0d_valid", i), 32'(bus.axis_m_tvalid), 1);
            check($sformatf("t4_stall%0d_data", i), 32'(bus.axis_m_tdata), 32'h0012);
            check($sformatf("t4_stall%0d_last", i), 32'(bus.axis_m_tlast), 0);
            check($sformatf("t4_stall%0d_tid", i), 32'(bus.axis_m_tid), 1);
            check($sformatf("t4_stall%0d_ready", i), 32'(bus.axis_s_tready), 0);
        end
        bus.axis_m_tready = 1'b1;
        tick();
        check("t4_b2_data", 32'(bus.axis_m_tdata), 32'h00DE);
        check("t4_b2_last", 32'(bus.axis_m_tlast), 1);
        check("t4_b2_ready", 32'(bus.axis_s_tready), 0);
        tick();
        check("t4_end_valid", 32'(bus.axis_m_tvalid), 0);
        check("t4_gap_ready", 32'(bus.axis_s_tready), 0);
        check("t4_gap_busy", 32'(busy), 0);
        tick();
        check("t4_next_grant", 32'(bus.axis_s_tready), 32'h4);
        send_beat(2, 8'h80, 1'b1);
        expect_resp("t4b", 2'd2, 1'b1);

        // T5: reset in the middle of a 4-beat packet on port 1
        send_beat(1, 8'h11, 1'b0);
        send_beat(1, 8'h22, 1'b0);
        check("t5_busy", 32'(busy), 1);
        axis_aresetn = 1'b1;
        drive(1, 1'b0, 8'h00, 1'b0);
        tick();
        check_reset("t5_rst");
        axis_aresetn = 1'b0;
        drive(0, 1'b1, 8'h01, 1'b1);
        drive(1, 1'b1, 8'h33, 1'b0);
        drive(3, 1'b1, 8'h44, 1'b1);
        tick();
        check("t5_no_resp", 32'(bus.axis_m_tvalid), 0);
        check("t5_grant", 32'(bus.axis_s_tready), 32'h1);
        send_beat(0, 8'h01, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b0);
        drive(3, 1'b0, 8'h00, 1'b0);
        expect_resp("t5", 2'd0, 1'b1);
        check("t5_len", 32'(last_len), 1);

        // T6: port 1 drops valid for 3 cycles while port 2 requests
        drive(2, 1'b1, 8'h07, 1'b1);
        send_beat(1, 8'h01, 1'b0);
        drive(1, 1'b0, 8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_hold%0d", i), 32'(bus.axis_s_tready), 32'h2);
            tick();
        end
        send_beat(1, 8'h03, 1'b0);
        send_beat(1, 8'h01, 1'b1);
        expect_resp("t6a", 2'd1, 1'b0);
        check("t6a_len", 32'(last_len), 3);
        tick();
        check("t6_next_grant", 32'(bus.axis_s_tready), 32'h4);
        send_beat(2, 8'h07, 1'b1);
        expect_resp("t6b", 2'd2, 1'b1);
        check("t6b_len", 32'(last_len), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_stream_arbiter.md
Name: parity_stream_arbiter

Overview:
Shares one packet parity checker between N_PORTS AXI-stream requesters. Arbitrates at packet granularity, round-robin, and streams the granted packet through an XOR parity accumulator. At packet end it emits a response burst on a single master stream, tagged with the source port ID. It sits in front of the parity test path and replaces per-port checkers.

Parameters:
N_PORTS, 4, number of slave stream requesters (2..8)
ID_W, 2, width of source ID, >= clog2(N_PORTS)
CNT_W, 16, width of the per-packet beat counter

Ports:
a_clk  in  1  clock, all logic on rising edge
axis_aresetn  in  1  reset, synchronous, active-high (asserted = 1)
axis_s_tvalid  in  N_PORTS  per-port beat valid
axis_s_tdata  in  8*N_PORTS  per-port data, port i at bits [8i+7:8i]
axis_s_tlast  in  N_PORTS  per-port last beat of packet
axis_s_tready  out  N_PORTS  per-port ready, at most one bit high
axis_m_tvalid  out  1  response beat valid
axis_m_tdata  out  8  response beat data
axis_m_tlast  out  1  last beat of response
axis_m_tid  out  ID_W  source port of current response
axis_m_tready  in  1  downstream ready
busy  out  1  high in any state other than IDLE
last_len  out  CNT_W  beat count of most recently completed packet

Behaviour:
- Reset, sampled on a_clk rise: state=IDLE, rr_ptr=0, grant=0, parity=0, beat_cnt=0, last_len=0. Outputs: all axis_s_tready=0, axis_m_tvalid=0, axis_m_tdata=8'h00, axis_m_tlast=0, axis_m_tid=0, busy=0. Reset mid-packet or mid-response: the partial packet is dropped and no response is emitted.
- States: IDLE, STREAM, RESP0, RESP1, RESP2.
- IDLE: if any axis_s_tvalid is high, grant = first index with tvalid high, searching from rr_ptr upward and wrapping modulo N_PORTS. Clear parity and beat_cnt, then go to STREAM. This costs one cycle of arbitration latency. With no tvalid, stay in IDLE.
- STREAM: axis_s_tready[grant]=1 (decoded from registered state and grant). All other ready bits are 0. A beat transfers when valid&ready. On each transfer: parity ^= XOR-reduce(data) and beat_cnt++. beat_cnt saturates at all-ones.
- Transfer with tlast=1: last_len = beat_cnt+1 (saturating), rr_ptr = (grant+1) mod N_PORTS, go to RESP0. Ready drops the next cycle. The final parity includes the tlast beat.
- Response start: axis_m_tvalid rises the cycle after the tlast transfer, with axis_m_tid=grant.
- Odd packet parity: RESP0 drives a single beat 8'hFF with tlast=1.
- Even packet parity: RESP0, RESP1, RESP2 drive 8'hAB, 8'h12, 8'hDE. Only the 8'hDE beat has tlast=1.
- A response beat advances only when axis_m_tready=1. While stalled, tdata, tlast and tid are held stable and tvalid stays high.
- After the last response beat is accepted: axis_m_tvalid=0, tdata=0, tlast=0, state=IDLE. The next arbitration happens in that IDLE cycle, so there is a minimum one-cycle gap between packets.
- Non-granted ports are never acknowledged; their data is not consumed or parity-checked.
- A tvalid drop mid-packet on the granted port is legal; the grant is held until tlast.
- Packet of one beat (tlast on the first beat) is legal.
- Fairness: with all ports continuously requesting, service order is 0,1,...,N_PORTS-1,0,...
- The master side is registered.

Test Plan:
1. Port 0 sends 3 beats 0x01,0x02,0x03 (tlast on 0x03), m_tready=1 -> even parity: response AB,12,DE on 3 consecutive cycles, tlast only on DE, tid=0, last_len=3; m_tvalid first high 1 cycle after the tlast transfer.
2. Port 2 sends single beat 0x07 with tlast -> odd parity: single beat FF with tlast=1, tid=2, last_len=1.
3. All 4 ports hold tvalid with 2-beat packets -> grants in order 0,1,2,3,0; at most one s_tready bit high in any cycle; non-granted ports' data stays unconsumed.
4. Even packet with m_tready low for 5 cycles on beat 12 -> 12 held stable with tvalid high, then DE follows after ready returns; the next grant only after DE is accepted.
5. Reset asserted after 2 beats of a 4-beat packet -> all outputs return to reset values the next cycle, no response, rr_ptr=0; port 0 granted first afterwards.
6. Granted port drops tvalid for 3 cycles mid-packet while another port requests -> grant held; parity covers only transferred beats; the other port is served after the response.
